// File: rtl/banco_regs.sv
// banco_regs: register bank with per-register ops, carry/zero flags and CLEAR_ALL sweep
module banco_regs #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [2:0]        sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  entrada,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  saida,
    output logic              carry,
    output logic              zero,
    output logic              busy
);
    localparam int NREG = 2 ** ADDR_W;
    typedef enum logic {OCIOSO = 1'b0, VARRENDO = 1'b1} estado_t;
    estado_t estado_q, estado_d;
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [WIDTH-1:0] cur;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic carry_q, carry_d;
    assign cur   = regs_q[addr];
    assign saida = regs_q[raddr];
    assign zero  = saida == '0;
    assign carry = carry_q;
    assign busy  = estado_q == VARRENDO;
    // Next state: the sweep has priority and blocks new ops; otherwise apply the accepted op
    always_comb begin
        regs_d   = regs_q;
        carry_d  = carry_q;
        estado_d = estado_q;
        idx_d    = idx_q;
        if (estado_q == VARRENDO) begin
            regs_d[idx_q] = '0;
            idx_d         = idx_q + 1'b1;
            estado_d      = idx_q == ADDR_W'(NREG - 1) ? OCIOSO : VARRENDO;
        end else if (en) begin
            case (sel)
                3'b000: begin regs_d[addr] = '0; carry_d = 1'b0; end
                3'b001: begin regs_d[addr] = entrada; carry_d = 1'b0; end
                3'b010: ;
                3'b011: {carry_d, regs_d[addr]} = {1'b0, cur} + (WIDTH+1)'(1);
                3'b100: {carry_d, regs_d[addr]} = {1'b0, cur} - (WIDTH+1)'(1);
                3'b101: {carry_d, regs_d[addr]} = {cur, 1'b0};
                3'b110: {regs_d[addr], carry_d} = {1'b0, cur};
                3'b111: begin estado_d = VARRENDO; idx_d = '0; carry_d = 1'b0; end
            endcase
        end
    end
    // State registers with synchronous active-low reset overriding any op
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q   <= '{default: '0};
            carry_q  <= 1'b0;
            estado_q <= OCIOSO;
            idx_q    <= '0;
        end else begin
            regs_q   <= regs_d;
            carry_q  <= carry_d;
            estado_q <= estado_d;
            idx_q    <= idx_d;
        end
    end
endmodule
